// File: rtl/rd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rd_pkg
// Brief   : Shared ALU op codes, RV64 opcode/funct3 constants and types for
//           the issue stage and the ALU.
// Revision: 1.0 - initial release
// ============================================================================
package rd_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 4'd0;
    localparam alu_op_t ALU_SUB = 4'd1;
    localparam alu_op_t ALU_AND = 4'd2;
    localparam alu_op_t ALU_OR  = 4'd3;
    localparam alu_op_t ALU_XOR = 4'd4;
    localparam alu_op_t ALU_SLL = 4'd5;
    localparam alu_op_t ALU_SRL = 4'd6;
    localparam alu_op_t ALU_SRA = 4'd7;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

endpackage
`default_nettype wire

// File: rtl/rd_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module  : rd_fwd_mux
// Brief   : Single-source operand select: x0, EX forward, MEM forward, or RF.
// Revision: 1.0 - initial release
// ============================================================================
module rd_fwd_mux
    import rd_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_idx,
    input  logic [XLEN-1:0]   rf_data,
    input  logic              ex_en,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_data,
    input  logic              ex_is_load,
    input  logic              mem_en,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    output logic [XLEN-1:0]   fwd_data
);

    logic w_ex_hit;
    logic w_mem_hit;

    // A load in EX has no data yet; the hazard logic stalls instead.
    assign w_ex_hit  = ex_en && !ex_is_load && (ex_rd != '0) && (ex_rd == rs_idx);
    assign w_mem_hit = mem_en && (mem_rd != '0) && (mem_rd == rs_idx);

    always_comb begin
        fwd_data = rf_data;
        if (rs_idx == '0) begin
            fwd_data = '0;
        end else if (w_ex_hit) begin
            fwd_data = ex_data;
        end else if (w_mem_hit) begin
            fwd_data = mem_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rd_alu_issue.sv
`default_nettype none
// ============================================================================
// Module  : rd_alu_issue
// Brief   : RV64 integer issue stage: operand forwarding, load-use stall and
//           ALU op decode into a one-entry output register.
//           Optional macro RD_ISSUE_PERF_EN adds issue/stall counters.
// Revision: 1.0 - initial release
// ============================================================================
module rd_alu_issue
    import rd_pkg::*;
#(
    parameter int XLEN   = 64,
`ifdef RD_ISSUE_PERF_EN
    parameter int CNT_W  = 32,
`endif
    parameter int REG_AW = 5
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              flush_in,
    input  logic              dec_valid_in,
    output logic              dec_ready_o,
    input  logic [31:0]       dec_instr_in,
    input  logic [XLEN-1:0]   dec_pc_in,
    input  logic [XLEN-1:0]   rs1_data_in,
    input  logic [XLEN-1:0]   rs2_data_in,
    input  logic              ex_fwd_en_in,
    input  logic [REG_AW-1:0] ex_fwd_rd_in,
    input  logic [XLEN-1:0]   ex_fwd_data_in,
    input  logic              ex_is_load_in,
    input  logic              mem_fwd_en_in,
    input  logic [REG_AW-1:0] mem_fwd_rd_in,
    input  logic [XLEN-1:0]   mem_fwd_data_in,
    output logic              alu_valid_o,
    input  logic              alu_ready_in,
    output logic [XLEN-1:0]   A_o,
    output logic [XLEN-1:0]   B_o,
    output logic [3:0]        op_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              wb_en_o,
`ifdef RD_ISSUE_PERF_EN
    output logic [CNT_W-1:0]  perf_issued_o,
    output logic [CNT_W-1:0]  perf_stall_o,
`endif
    output logic              illegal_o
);

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic              w_alt;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic [REG_AW-1:0] w_rd;
    logic [XLEN-1:0]   w_imm_i;
    logic [XLEN-1:0]   w_imm_u;
    logic [XLEN-1:0]   w_rs1_val;
    logic [XLEN-1:0]   w_rs2_val;
    logic              w_is_op;
    logic              w_is_op_imm;
    logic              w_hazard;
    logic              w_accept;
    logic              w_legal;
    logic              w_shift;
    alu_op_t           w_op;
    logic [XLEN-1:0]   w_a;
    logic [XLEN-1:0]   w_b;

    logic              r_valid;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    alu_op_t           r_op;
    logic [REG_AW-1:0] r_rd;
    logic              r_wb_en;
    logic              r_illegal;

    assign w_opcode    = dec_instr_in[6:0];
    assign w_rd        = dec_instr_in[11:7];
    assign w_funct3    = dec_instr_in[14:12];
    assign w_rs1       = dec_instr_in[19:15];
    assign w_rs2       = dec_instr_in[24:20];
    assign w_alt       = dec_instr_in[30];
    assign w_imm_i     = {{(XLEN-12){dec_instr_in[31]}}, dec_instr_in[31:20]};
    assign w_imm_u     = {{(XLEN-32){dec_instr_in[31]}}, dec_instr_in[31:12], 12'b0};
    assign w_is_op     = (w_opcode == OPC_OP);
    assign w_is_op_imm = (w_opcode == OPC_OP_IMM);

    rd_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs_idx     (w_rs1),
        .rf_data    (rs1_data_in),
        .ex_en      (ex_fwd_en_in),
        .ex_rd      (ex_fwd_rd_in),
        .ex_data    (ex_fwd_data_in),
        .ex_is_load (ex_is_load_in),
        .mem_en     (mem_fwd_en_in),
        .mem_rd     (mem_fwd_rd_in),
        .mem_data   (mem_fwd_data_in),
        .fwd_data   (w_rs1_val)
    );

    rd_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs_idx     (w_rs2),
        .rf_data    (rs2_data_in),
        .ex_en      (ex_fwd_en_in),
        .ex_rd      (ex_fwd_rd_in),
        .ex_data    (ex_fwd_data_in),
        .ex_is_load (ex_is_load_in),
        .mem_en     (mem_fwd_en_in),
        .mem_rd     (mem_fwd_rd_in),
        .mem_data   (mem_fwd_data_in),
        .fwd_data   (w_rs2_val)
    );

    // Source usage is by opcode only, so an unsupported OP funct3 can still stall.
    assign w_hazard = ex_is_load_in && (ex_fwd_rd_in != '0) &&
                      (((w_is_op || w_is_op_imm) && (w_rs1 == ex_fwd_rd_in)) ||
                       (w_is_op && (w_rs2 == ex_fwd_rd_in)));

    assign dec_ready_o = (!r_valid || alu_ready_in) && !w_hazard && !flush_in;
    assign w_accept    = dec_valid_in && dec_ready_o;

    always_comb begin
        w_legal = 1'b0;
        w_shift = 1'b0;
        w_op    = ALU_ADD;
        w_a     = '0;
        w_b     = '0;
        if (w_is_op || w_is_op_imm) begin
            w_legal = 1'b1;
            w_a     = w_rs1_val;
            w_b     = w_is_op ? w_rs2_val : w_imm_i;
            case (w_funct3)
                F3_ADD_SUB: w_op = (w_is_op && w_alt) ? ALU_SUB : ALU_ADD;
                F3_AND:     w_op = ALU_AND;
                F3_OR:      w_op = ALU_OR;
                F3_XOR:     w_op = ALU_XOR;
                F3_SLL: begin
                    w_op    = ALU_SLL;
                    w_shift = 1'b1;
                end
                F3_SRL_SRA: begin
                    w_op    = w_alt ? ALU_SRA : ALU_SRL;
                    w_shift = 1'b1;
                end
                default:    w_legal = 1'b0;
            endcase
        end else if (w_opcode == OPC_LUI) begin
            w_legal = 1'b1;
            w_b     = w_imm_u;
        end else if (w_opcode == OPC_AUIPC) begin
            w_legal = 1'b1;
            w_a     = dec_pc_in;
            w_b     = w_imm_u;
        end
        if (w_shift) begin
            w_b = {{(XLEN-6){1'b0}}, w_b[5:0]};
        end
        if (!w_legal) begin
            w_op = ALU_ADD;
            w_a  = '0;
            w_b  = '0;
        end
    end

    // Consume-and-accept in the same cycle overwrites the entry without a bubble.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= ALU_ADD;
            r_rd      <= '0;
            r_wb_en   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (flush_in) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
                r_a     <= w_a;
                r_b     <= w_b;
                r_op    <= w_op;
                r_rd    <= w_rd;
                r_wb_en <= w_legal && (w_rd != '0);
            end else if (alu_ready_in) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign alu_valid_o = r_valid;
    assign A_o         = r_a;
    assign B_o         = r_b;
    assign op_o        = r_op;
    assign rd_o        = r_rd;
    assign wb_en_o     = r_wb_en;
    assign illegal_o   = r_illegal;

`ifdef RD_ISSUE_PERF_EN
    logic [CNT_W-1:0] r_perf_issued;
    logic [CNT_W-1:0] r_perf_stall;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_accept && (r_perf_issued != '1)) begin
                r_perf_issued <= r_perf_issued + 1'b1;
            end
            if (dec_valid_in && w_hazard && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
        end
    end

    assign perf_issued_o = r_perf_issued;
    assign perf_stall_o  = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: doc/rd_alu_issue.md
Name: rd_alu_issue

Overview:
- Issue stage directly upstream of the 64-bit ALU.
- Accepts one decoded RV64 integer instruction per cycle from decode through a valid/ready handshake, and resolves its operands from the register file or from forwarding.
- Translates opcode/funct3/funct7 into the 4-bit ALU op code and registers A/B/op into a one-entry pipeline register that drives the ALU inputs.
- Detects load-use hazards and inserts bubbles.

Parameters:
- XLEN, 64, operand and result width.
- REG_AW, 5, register index width.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- flush_in  input  1  kill the held entry and any incoming instruction (branch redirect).
- dec_valid_in  input  1  decode presents an instruction.
- dec_ready_o  output  1  issue accepts the instruction this cycle.
- dec_instr_in  input  32  raw instruction.
- dec_pc_in  input  XLEN  instruction PC.
- rs1_data_in  input  XLEN  register file read port 1.
- rs2_data_in  input  XLEN  register file read port 2.
- ex_fwd_en_in  input  1  EX result is valid for forwarding.
- ex_fwd_rd_in  input  REG_AW  EX destination register.
- ex_fwd_data_in  input  XLEN  EX result.
- ex_is_load_in  input  1  EX holds a load (its data is not yet available).
- mem_fwd_en_in  input  1  MEM result is valid for forwarding.
- mem_fwd_rd_in  input  REG_AW  MEM destination register.
- mem_fwd_data_in  input  XLEN  MEM result.
- alu_valid_o  output  1  A_o/B_o/op_o hold a valid instruction.
- alu_ready_in  input  1  the ALU stage consumes the entry.
- A_o  output  XLEN  ALU operand A.
- B_o  output  XLEN  ALU operand B.
- op_o  output  4  ALU op code.
- rd_o  output  REG_AW  destination register.
- wb_en_o  output  1  result is written back.
- illegal_o  output  1  pulses one cycle when an unsupported instruction is accepted.

Behaviour:
- Reset: alu_valid_o=0, A_o=0, B_o=0, op_o=ADD, rd_o=0, wb_en_o=0, illegal_o=0. Reset overrides flush and any handshake in the same cycle.
- Handshake: dec_ready_o = (!alu_valid_o || alu_ready_in) && !hazard && !flush_in. Transfer occurs when dec_valid_in && dec_ready_o. Latency is one cycle from acceptance to alu_valid_o.
- While alu_valid_o && !alu_ready_in, all outputs hold stable.
- hazard = ex_is_load_in && ex_fwd_rd_in!=0 && ex_fwd_rd_in matches any rs field the instruction uses (rs1 for OP/OP-IMM; rs2 for OP).
- On hazard: no acceptance. If the entry was consumed, alu_valid_o goes to 0 (bubble).
- Decode:
  - OP (0110011): funct3 000 → ADD/SUB (SUB when funct7[5]); 111 → AND; 110 → OR; 100 → XOR; 001 → SLL; 101 → SRL/SRA (SRA when funct7[5]).
  - OP-IMM (0010011): same mapping with B = sign-extended I-immediate. ADDI never yields SUB.
  - LUI: A = 0, B = sign-extended U-immediate, op ADD.
  - AUIPC: A = pc, B = U-immediate, op ADD.
- For shifts, B_o[5:0] = shamt (rs2[5:0] or imm[5:0]) and B_o[63:6] = 0.
- Anything else, including SLT/SLTU: accepted, alu_valid_o=1, op ADD, A=B=0, wb_en_o=0, illegal_o=1 for one cycle.
- Forwarding per source: EX match (en && rd!=0 && rd==rs) takes priority, then MEM match, then the register file. Source x0 always reads 0. EX forwarding is suppressed when ex_is_load_in (the hazard stalls instead).
- wb_en_o = legal && rd!=0.
- flush_in: next cycle alu_valid_o=0 regardless of alu_ready_in; dec_ready_o=0 during the flush cycle.
- Simultaneous consume and accept: the register is overwritten with no bubble, giving full throughput.

Optional Feature:
- Macro RD_ISSUE_PERF_EN.
- When defined, adds outputs perf_issued_o [CNT_W] (count of transfers) and perf_stall_o [CNT_W] (cycles with dec_valid_in && hazard).
- Both counters saturate at all-ones and clear on rst_in.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package rd_pkg holds: ALU op-code localparams (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, 4-bit), RV opcode constants (OP, OP_IMM, LUI, AUIPC), funct3 constants, and the alu_op_t typedef. The ALU imports the same package.
- One sub-module, rd_fwd_mux: a combinational single-source forwarding select, instantiated twice.

Test Plan:
- Reset, then ADD x3,x1,x2 with rs1=5, rs2=7, no forwarding → next cycle alu_valid_o=1, A_o=5, B_o=7, op_o=ADD, rd_o=3, wb_en_o=1.
- SUB x4,x1,x2 with EX forwarding x1=100 and MEM forwarding x1=50 → A_o=100 (EX wins), op_o=SUB.
- Load to x5 in EX, then ADD x6,x5,x0 → dec_ready_o=0 for one cycle and a bubble appears (alu_valid_o=0); after the load clears, A_o=MEM data.
- SRAI x7,x1,63 with rs1=0x8000000000000000 → B_o=63, op_o=SRA. SLLI with imm[11:6] set → B_o[63:6]=0.
- alu_ready_in=0 for 3 cycles with dec_valid_in=1 → outputs stable, dec_ready_o=0; flush_in asserted mid-stall → alu_valid_o=0 next cycle.
- SLT instruction → illegal_o=1 for one cycle, wb_en_o=0. ADDI x0,x0,1 → wb_en_o=0.
